id_stage_ctrl: RTL and testbench

ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/imm_decode.sv | 91 +++++++++
 rtl/id_stage_ctrl.sv | 128 ++++++++++++
 tb/tb_id_stage_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS decode constants and ID-stage state type
//
// Purpose: opcode/funct constants, ALU-control encodings, out_ctrl bit
// indices and the ID/EX slot FSM state enum used by imm_decode and
// id_stage_ctrl.
// Ports: none (package).
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control encodings
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  // out_ctrl = {regdst, alusrc, branch, bne, memread, memwrite, regwrite}
  localparam int CTRL_REGDST   = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_BNE      = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_REGWRITE = 0;

  // ID/EX slot occupancy
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_e;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational MIPS instruction decoder
//
// Purpose: maps a 32-bit instruction to control bits, ALU op, extended
// immediate and an illegal flag. Unsupported encodings give all-zero
// control/ALU/immediate with illegal=1.
// Ports:
//   instr    in  32  instruction word
//   ctrl     out 7   {regdst, alusrc, branch, bne, memread, memwrite, regwrite}
//   alu_ctrl out 4   ALU operation
//   imm      out 32  extended immediate (0 for R-type)
//   illegal  out 1   unsupported opcode/funct
module imm_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  ctrl,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sx;
  logic [31:0] imm_zx;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm_sx = {{16{instr[15]}}, instr[15:0]};
  assign imm_zx = {16'h0000, instr[15:0]};

  always_comb begin
    ctrl     = '0;
    alu_ctrl = ALU_ADD;
    imm      = '0;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl[CTRL_REGDST]   = 1'b1;
        ctrl[CTRL_REGWRITE] = 1'b1;
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: begin
            ctrl    = '0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        ctrl[CTRL_ALUSRC]   = 1'b1;
        ctrl[CTRL_REGWRITE] = 1'b1;
        alu_ctrl = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        imm      = imm_sx;
      end
      OP_ANDI, OP_ORI: begin
        ctrl[CTRL_ALUSRC]   = 1'b1;
        ctrl[CTRL_REGWRITE] = 1'b1;
        alu_ctrl = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
        imm      = imm_zx;
      end
      OP_LUI: begin
        ctrl[CTRL_ALUSRC]   = 1'b1;
        ctrl[CTRL_REGWRITE] = 1'b1;
        imm = {instr[15:0], 16'h0000};
      end
      OP_LW: begin
        ctrl[CTRL_ALUSRC]   = 1'b1;
        ctrl[CTRL_MEMREAD]  = 1'b1;
        ctrl[CTRL_REGWRITE] = 1'b1;
        imm = imm_sx;
      end
      OP_SW: begin
        ctrl[CTRL_ALUSRC]   = 1'b1;
        ctrl[CTRL_MEMWRITE] = 1'b1;
        imm = imm_sx;
      end
      OP_BEQ, OP_BNE: begin
        ctrl[CTRL_BRANCH] = 1'b1;
        ctrl[CTRL_BNE]    = (opcode == OP_BNE);
        alu_ctrl = ALU_SUB;
        imm      = imm_sx;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// rtl/id_stage_ctrl.sv - MIPS decode stage with registered ID/EX slot
//
// Purpose: decodes incoming instructions into a one-entry ID/EX slot with
// valid/ready handshakes, load-use bubble insertion, branch flush and a
// saturating bubble counter.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/instr      decode-side handshake and instruction
//   flush                        taken branch, kills slot and incoming instr
//   out_valid/out_ready          EX-side handshake
//   out_ctrl, out_alu_ctrl       decoded control of the held instruction
//   out_imm, out_rs/rt/rd        immediate and register fields
//   out_illegal                  held instruction is unsupported
//   stall_cnt                    saturating count of load-use bubbles
module id_stage_ctrl
  import mips_pkg::*;
#(
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_ctrl,
  output logic [3:0]  out_alu_ctrl,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  output logic [15:0] stall_cnt
);

  logic [6:0]  dec_ctrl;
  logic [3:0]  dec_alu;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  imm_decode u_imm_decode (
    .instr    (instr),
    .ctrl     (dec_ctrl),
    .alu_ctrl (dec_alu),
    .imm      (dec_imm),
    .illegal  (dec_illegal)
  );

  state_e      state_q;
  logic        valid_q;
  logic [6:0]  ctrl_q;
  logic [3:0]  alu_q;
  logic [31:0] imm_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic        illegal_q;
  logic [15:0] stall_q;

  logic free;
  logic hazard;

  assign free = (state_q != ST_FULL) || out_ready;

  // Only a held load can conflict; BUBBLE/EMPTY never do, so the dependent
  // instruction goes through on the cycle after the bubble.
  assign hazard = HAZARD_EN && in_valid && (state_q == ST_FULL) &&
                  ctrl_q[CTRL_MEMREAD] && (rt_q != 5'd0) &&
                  ((rt_q == instr[25:21]) || (rt_q == instr[20:16]));

  // Under flush the incoming instruction is taken off the bus and dropped.
  assign in_ready = !rst && (flush || (free && !hazard));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      alu_q     <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      stall_q   <= '0;
    end else if (flush || free) begin
      // Default is an empty slot; load or bubble override below.
      state_q   <= ST_EMPTY;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      alu_q     <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      if (!flush) begin
        if (hazard) begin
          state_q <= ST_BUBBLE;
          if (stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end else if (in_valid) begin
          state_q   <= ST_FULL;
          valid_q   <= 1'b1;
          ctrl_q    <= dec_ctrl;
          alu_q     <= dec_alu;
          imm_q     <= dec_imm;
          rs_q      <= instr[25:21];
          rt_q      <= instr[20:16];
          rd_q      <= instr[15:11];
          illegal_q <= dec_illegal;
        end
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_ctrl     = ctrl_q;
  assign out_alu_ctrl = alu_q;
  assign out_imm      = imm_q;
  assign out_rs       = rs_q;
  assign out_rt       = rt_q;
  assign out_rd       = rd_q;
  assign out_illegal  = illegal_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb/tb_id_stage_ctrl.sv - self-checking bench for id_stage_ctrl
module tb_id_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_ctrl;
  logic [3:0]  out_alu_ctrl;
  logic [31:0] out_imm;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [15:0] stall_cnt;

  id_stage_ctrl #(.HAZARD_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_alu_ctrl (out_alu_ctrl),
    .out_imm      (out_imm),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        ill;
  } slot_t;

  int n_checks = 0;
  int n_errors = 0;

  logic        m_valid;
  slot_t       m_slot;
  logic [15:0] m_stall;
  logic        obs_ready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction table.
  function automatic slot_t ref_decode(input logic [31:0] ins);
    slot_t s;
    logic [5:0] op;
    logic [5:0] fn;
    logic [15:0] i16;
    logic regdst, alusrc, branch, bne, memread, memwrite, regwrite;
    op = ins[31:26];
    fn = ins[5:0];
    i16 = ins[15:0];
    {regdst, alusrc, branch, bne, memread, memwrite, regwrite} = 7'b0;
    s = '0;
    s.rs = ins[25:21];
    s.rt = ins[20:16];
    s.rd = ins[15:11];
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
      regdst = 1; regwrite = 1;
      s.alu = (fn == 6'h20) ? 4'd0 : (fn == 6'h22) ? 4'd1 : (fn == 6'h24) ? 4'd2 :
              (fn == 6'h25) ? 4'd3 : 4'd5;
    end else if (op == 6'h08 || op == 6'h0A) begin
      alusrc = 1; regwrite = 1;
      s.alu = (op == 6'h08) ? 4'd0 : 4'd5;
      s.imm = {{16{i16[15]}}, i16};
    end else if (op == 6'h0C || op == 6'h0D) begin
      alusrc = 1; regwrite = 1;
      s.alu = (op == 6'h0C) ? 4'd2 : 4'd3;
      s.imm = {16'h0, i16};
    end else if (op == 6'h0F) begin
      alusrc = 1; regwrite = 1;
      s.imm = {i16, 16'h0};
    end else if (op == 6'h23) begin
      alusrc = 1; memread = 1; regwrite = 1;
      s.imm = {{16{i16[15]}}, i16};
    end else if (op == 6'h2B) begin
      alusrc = 1; memwrite = 1;
      s.imm = {{16{i16[15]}}, i16};
    end else if (op == 6'h04 || op == 6'h05) begin
      branch = 1; bne = (op == 6'h05);
      s.alu = 4'd1;
      s.imm = {{16{i16[15]}}, i16};
    end else begin
      s.ill = 1'b1;
    end
    s.ctrl = {regdst, alusrc, branch, bne, memread, memwrite, regwrite};
    return s;
  endfunction

  // One clock: drive inputs, check in_ready, advance the model, check outputs.
  task automatic cycle(input logic r, input logic iv, input logic [31:0] ins,
                       input logic fl, input logic ordy);
    logic hz, free, exp_ready, nv;
    slot_t ns;
    logic [15:0] nst;
    @(negedge clk);
    rst = r; in_valid = iv; instr = ins; flush = fl; out_ready = ordy;
    #1;
    hz = iv && m_valid && m_slot.ctrl[2] && (m_slot.rt != 5'd0) &&
         (m_slot.rt == ins[25:21] || m_slot.rt == ins[20:16]);
    free = !m_valid || ordy;
    exp_ready = !r && (fl || (free && !hz));
    obs_ready = in_ready;
    check_eq("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    nv = m_valid; ns = m_slot; nst = m_stall;
    if (r) begin
      nv = 0; ns = '0; nst = 0;
    end else if (fl) begin
      nv = 0; ns = '0;
    end else if (free) begin
      if (hz) begin
        nv = 0; ns = '0;
        if (m_stall != 16'hFFFF) nst = m_stall + 1;
      end else if (iv) begin
        nv = 1; ns = ref_decode(ins);
      end else begin
        nv = 0; ns = '0;
      end
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_slot = ns; m_stall = nst;
    check_eq("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check_eq("out_ctrl", {25'b0, out_ctrl}, {25'b0, m_slot.ctrl});
    check_eq("out_alu_ctrl", {28'b0, out_alu_ctrl}, {28'b0, m_slot.alu});
    check_eq("out_imm", out_imm, m_slot.imm);
    check_eq("out_rs", {27'b0, out_rs}, {27'b0, m_slot.rs});
    check_eq("out_rt", {27'b0, out_rt}, {27'b0, m_slot.rt});
    check_eq("out_rd", {27'b0, out_rd}, {27'b0, m_slot.rd});
    check_eq("out_illegal", {31'b0, out_illegal}, {31'b0, m_slot.ill});
    check_eq("stall_cnt", {16'b0, stall_cnt}, {16'b0, m_stall});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [11];
    logic [5:0] fns [6];
    logic [5:0] op;
    logic [31:0] w;
    ops = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};
    op = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 3) == 0) op = 6'h23;
    w = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
    if (op == 6'h00) w[5:0] = fns[$urandom_range(0, 5)];
    return w;
  endfunction

  initial begin
    m_valid = 0; m_slot = '0; m_stall = 0; obs_ready = 0;
    rst = 1; in_valid = 0; instr = 0; flush = 0; out_ready = 1;

    cycle(1, 1, 32'h2109FFFF, 0, 1);
    check_eq("reset_valid", {31'b0, out_valid}, 32'd0);
    check_eq("reset_stall", {16'b0, stall_cnt}, 32'd0);

    cycle(0, 1, 32'h2109FFFF, 0, 1);
    check_eq("addi_imm", out_imm, 32'hFFFFFFFF);
    check_eq("addi_ctrl", {25'b0, out_ctrl}, 32'h21);
    cycle(0, 1, 32'h35098000, 0, 1);
    check_eq("ori_imm", out_imm, 32'h00008000);
    check_eq("ori_alu", {28'b0, out_alu_ctrl}, 32'd3);
    cycle(0, 1, 32'h3C091234, 0, 1);
    check_eq("lui_imm", out_imm, 32'h12340000);

    // Load-use bubble
    cycle(0, 1, 32'h8D090000, 0, 1);
    cycle(0, 1, 32'h01285020, 0, 1);
    check_eq("lu_ready", {31'b0, obs_ready}, 32'd0);
    check_eq("lu_bubble", {31'b0, out_valid}, 32'd0);
    check_eq("lu_stall", {16'b0, stall_cnt}, 32'd1);
    cycle(0, 1, 32'h01285020, 0, 1);
    check_eq("lu_add_rd", {27'b0, out_rd}, 32'd10);
    cycle(0, 1, 32'h8C000000, 0, 1);
    cycle(0, 1, 32'h01285020, 0, 1);
    check_eq("lw0_ready", {31'b0, obs_ready}, 32'd1);
    check_eq("lw0_stall", {16'b0, stall_cnt}, 32'd1);

    // Hold for three cycles, then release
    cycle(0, 1, 32'h2109FFFF, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 32'h35098000, 0, 0);
      check_eq("hold_ready", {31'b0, obs_ready}, 32'd0);
      check_eq("hold_imm", out_imm, 32'hFFFFFFFF);
    end
    cycle(0, 1, 32'h35098000, 0, 1);
    check_eq("release_imm", out_imm, 32'h00008000);

    // Flush with held slot and out_ready low
    cycle(0, 1, 32'h3C091234, 1, 0);
    check_eq("flush_valid", {31'b0, out_valid}, 32'd0);
    // Flush coincident with a load-use hazard
    cycle(0, 1, 32'h8D090000, 0, 1);
    cycle(0, 1, 32'h01285020, 1, 1);
    check_eq("flush_hz_stall", {16'b0, stall_cnt}, 32'd1);

    // Illegal opcode
    cycle(0, 1, 32'hFC000000, 0, 1);
    check_eq("ill_valid", {31'b0, out_valid}, 32'd1);
    check_eq("ill_flag", {31'b0, out_illegal}, 32'd1);
    check_eq("ill_ctrl", {25'b0, out_ctrl}, 32'd0);

    // Reset while in BUBBLE
    cycle(0, 1, 32'h8D090000, 0, 1);
    cycle(0, 1, 32'h01285020, 0, 1);
    cycle(1, 1, 32'h01285020, 0, 1);
    check_eq("rst_bub_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_bub_rt", {27'b0, out_rt}, 32'd0);
    check_eq("rst_bub_stall", {16'b0, stall_cnt}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            rand_instr(),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
